set_assoc_cache_ctrl: RTL and testbench

Parametrised N-way set-associative, one-word-per-line cache with an integrated controller.
- Sits between the processor port and the word RAM.
- Write-through with write-allocate; true-LRU replacement via per-set age counters.
- Valid/handshake interfaces on both sides; hit/miss statistics counters.

---
 rtl/cache_pkg.sv | 26 ++
 rtl/cache_lru.sv | 63 ++++++
 rtl/set_assoc_cache_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_set_assoc_cache_ctrl.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and width helpers for the set-associative cache controller.
// The controller and its LRU sub-block both derive their field widths from here.
package cache_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_MEM_RD,
    ST_MEM_WR,
    ST_RESP
  } state_t;

  function automatic int calc_idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int calc_tag_w(input int addr_w, input int sets);
    return addr_w - $clog2(sets) - 2;
  endfunction

  // Width of a per-way age counter; it also serves as the way-index width.
  function automatic int calc_age_w(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/cache_lru.sv
// Per-set true-LRU age tracking: age 0 is most recent, WAYS-1 is the eviction candidate.
// Ages in a set always form a permutation of 0..WAYS-1.
module cache_lru
  import cache_pkg::*;
#(
  parameter int WAYS = 4,
  parameter int SETS = 256,
  localparam int AGE_W = calc_age_w(WAYS),
  localparam int IDX_W = calc_idx_w(SETS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] i_idx,
  input  logic [WAYS-1:0]  i_valid,
  output logic [AGE_W-1:0] o_victim,
  input  logic             i_upd_en,
  input  logic [AGE_W-1:0] i_upd_way
);

  logic [AGE_W-1:0] r_age [SETS][WAYS];
  logic [AGE_W-1:0] w_old;
  logic             w_inv_found;

  assign w_old = r_age[i_idx][i_upd_way];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          r_age[s][w] <= AGE_W'(w);
        end
      end
    end else if (i_upd_en) begin
      for (int w = 0; w < WAYS; w++) begin
        if (AGE_W'(w) == i_upd_way) begin
          r_age[i_idx][w] <= '0;
        end else if (r_age[i_idx][w] < w_old) begin
          r_age[i_idx][w] <= r_age[i_idx][w] + AGE_W'(1);
        end
      end
    end
  end

  // Empty ways are filled lowest-first before anything is evicted.
  always_comb begin
    o_victim    = '0;
    w_inv_found = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!w_inv_found && !i_valid[w]) begin
        w_inv_found = 1'b1;
        o_victim    = AGE_W'(w);
      end
    end
    if (!w_inv_found) begin
      for (int w = 0; w < WAYS; w++) begin
        if (r_age[i_idx][w] == AGE_W'(WAYS - 1)) begin
          o_victim = AGE_W'(w);
        end
      end
    end
  end

endmodule

// File: rtl/set_assoc_cache_ctrl.sv
// N-way set-associative, one-word-per-line, write-through/write-allocate cache
// with its controller FSM, memory-side request port and hit/miss statistics.
module set_assoc_cache_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int WAYS   = 4,
  parameter int SETS   = 256,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_hit,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt,
  output state_t            dbg_state
);

  localparam int IDX_W = calc_idx_w(SETS);
  localparam int TAG_W = calc_tag_w(ADDR_W, SETS);
  localparam int WAY_W = calc_age_w(WAYS);

  // Handshake: a CPU request is taken only on a clock edge where cpu_req and
  // cpu_ready are both high; cpu_done then pulses once for that request. On the
  // memory side mem_req stays high until the single-cycle mem_ack pulse.
  state_t              r_state, w_next;
  logic                r_we;
  logic [ADDR_W-3:0]   r_waddr;
  logic [DATA_W-1:0]   r_wdata;
  logic [WAY_W-1:0]    r_way;
  logic                r_hit;
  logic [DATA_W-1:0]   r_rdata;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [CNT_W-1:0]    r_hit_cnt;
  logic [CNT_W-1:0]    r_miss_cnt;
  logic [WAYS-1:0]     r_valid [SETS];
  logic [TAG_W-1:0]    r_tag   [SETS][WAYS];
  logic [DATA_W-1:0]   r_data  [SETS][WAYS];

  logic [IDX_W-1:0]    w_idx;
  logic [TAG_W-1:0]    w_tag;
  logic                w_hit;
  logic [WAY_W-1:0]    w_hit_way;
  logic [WAY_W-1:0]    w_victim;
  logic [WAY_W-1:0]    w_way;
  logic                w_fill_en;
  logic [WAY_W-1:0]    w_fill_way;
  logic [DATA_W-1:0]   w_fill_data;
  logic                w_unused_addr;

  assign w_unused_addr = ^cpu_addr[1:0];
  assign w_idx         = r_waddr[IDX_W-1:0];
  assign w_tag         = r_waddr[ADDR_W-3:IDX_W];
  assign w_way         = w_hit ? w_hit_way : w_victim;

  assign cpu_ready = (r_state == ST_IDLE);
  assign cpu_done  = (r_state == ST_RESP);
  assign cpu_rdata = r_rdata;
  assign cpu_hit   = r_hit;
  assign mem_req   = (r_state == ST_MEM_RD) || (r_state == ST_MEM_WR);
  assign mem_we    = (r_state == ST_MEM_WR);
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign hit_cnt   = r_hit_cnt;
  assign miss_cnt  = r_miss_cnt;
  assign dbg_state = r_state;

  // Descending scan so that, should several ways ever match, the lowest wins.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(w);
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (cpu_req) w_next = ST_LOOKUP;
      ST_LOOKUP: begin
        if (r_we)       w_next = ST_MEM_WR;
        else if (w_hit) w_next = ST_RESP;
        else            w_next = ST_MEM_RD;
      end
      ST_MEM_RD: if (mem_ack) w_next = ST_RESP;
      ST_MEM_WR: if (mem_ack) w_next = ST_RESP;
      ST_RESP:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Writes allocate as they leave LOOKUP; read misses allocate when memory answers.
  always_comb begin
    w_fill_en   = 1'b0;
    w_fill_way  = r_way;
    w_fill_data = r_wdata;
    if (!rst) begin
      if ((r_state == ST_LOOKUP) && r_we) begin
        w_fill_en  = 1'b1;
        w_fill_way = w_way;
      end else if ((r_state == ST_MEM_RD) && mem_ack) begin
        w_fill_en   = 1'b1;
        w_fill_data = mem_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_we        <= 1'b0;
      r_waddr     <= '0;
      r_wdata     <= '0;
      r_way       <= '0;
      r_hit       <= 1'b0;
      r_rdata     <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_hit_cnt   <= '0;
      r_miss_cnt  <= '0;
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
      end
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: begin
          if (cpu_req) begin
            r_we    <= cpu_we;
            r_waddr <= cpu_addr[ADDR_W-1:2];
            r_wdata <= cpu_wdata;
          end
        end
        ST_LOOKUP: begin
          r_way <= w_way;
          r_hit <= w_hit;
          if (!r_we && w_hit) begin
            r_rdata <= r_data[w_idx][w_hit_way];
          end else begin
            r_mem_addr  <= {r_waddr, 2'b00};
            r_mem_wdata <= r_wdata;
          end
        end
        ST_MEM_RD: if (mem_ack) r_rdata <= mem_rdata;
        ST_RESP: begin
          if (r_hit) begin
            if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + CNT_W'(1);
          end else begin
            if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
      if (w_fill_en) r_valid[w_idx][w_fill_way] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_fill_en) begin
      r_tag[w_idx][w_fill_way]  <= w_tag;
      r_data[w_idx][w_fill_way] <= w_fill_data;
    end
  end

  cache_lru #(
    .WAYS (WAYS),
    .SETS (SETS)
  ) u_lru (
    .clk       (clk),
    .rst       (rst),
    .i_idx     (w_idx),
    .i_valid   (r_valid[w_idx]),
    .o_victim  (w_victim),
    .i_upd_en  (r_state == ST_RESP),
    .i_upd_way (r_way)
  );

endmodule

// File: tb/tb_set_assoc_cache_ctrl.sv
// Bench for set_assoc_cache_ctrl: recency-timestamp cache model, memory responder
// with random latency, per-cycle compare process and directed literal pins.
module tb_set_assoc_cache_ctrl;
  import cache_pkg::*;

  localparam int SETS = 256;
  localparam int WAYS = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        cpu_ready, cpu_done, cpu_hit;
  logic [31:0] cpu_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] hit_cnt, miss_cnt;
  state_t      dbg_state;

  set_assoc_cache_ctrl #(
    .ADDR_W(32), .DATA_W(32), .WAYS(WAYS), .SETS(SETS), .CNT_W(32)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata), .cpu_hit(cpu_hit),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [21:0] m_tag   [SETS][WAYS];
  logic [31:0] m_data  [SETS][WAYS];
  bit          m_valid [SETS][WAYS];
  longint      m_last  [SETS][WAYS];
  longint      m_time;
  logic [31:0] mem [logic [29:0]];
  logic [33:0] exp_q [$];
  int          m_hits = 0;
  int          m_misses = 0;
  int          done_total = 0;

  bit          cur_mem_exp = 1'b0;
  bit          cur_mem_we = 1'b0;
  logic [31:0] cur_mem_addr = '0;
  logic [31:0] cur_mem_wdata = '0;
  int          mem_snap = 0;
  int          acc_cyc = 0;

  function automatic logic [31:0] mem_val(input logic [29:0] wa);
    if (mem.exists(wa)) return mem[wa];
    return {wa, 2'b11} ^ 32'h1357_9bdf;
  endfunction

  // Way 0 starts as most recently used, the highest way as least recently used.
  task automatic model_reset();
    for (int s = 0; s < SETS; s++) begin
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 1'b0;
        m_last[s][w]  = -longint'(w);
      end
    end
    m_time = 1;
  endtask

  task automatic model_access(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                              output bit exp_mem);
    int          idx, way, hw;
    logic [21:0] tag;
    logic [29:0] wa;
    logic [31:0] rd;
    bit          hit;
    idx = int'(addr[9:2]);
    tag = addr[31:10];
    wa  = addr[31:2];
    hw  = -1;
    for (int w = 0; w < WAYS; w++)
      if (hw < 0 && m_valid[idx][w] && m_tag[idx][w] == tag) hw = w;
    hit = (hw >= 0);
    if (hit) way = hw;
    else begin
      way = -1;
      for (int w = 0; w < WAYS; w++)
        if (way < 0 && !m_valid[idx][w]) way = w;
      if (way < 0) begin
        way = 0;
        for (int w = 1; w < WAYS; w++)
          if (m_last[idx][w] < m_last[idx][way]) way = w;
      end
    end
    rd = '0;
    if (we) begin
      mem[wa] = wdata;
      m_data[idx][way] = wdata;
    end else if (hit) begin
      rd = m_data[idx][way];
    end else begin
      rd = mem_val(wa);
      m_data[idx][way] = rd;
    end
    m_tag[idx][way]   = tag;
    m_valid[idx][way] = 1'b1;
    m_last[idx][way]  = m_time;
    m_time++;
    exp_mem       = we || !hit;
    cur_mem_exp   = exp_mem;
    cur_mem_we    = we;
    cur_mem_addr  = {wa, 2'b00};
    cur_mem_wdata = wdata;
    mem_snap      = mem_ops_seen;
    exp_q.push_back({we, hit, rd});
  endtask

  // ---------------- memory responder ----------------
  bit mem_auto = 1'b1;
  bit mem_busy = 1'b0;
  int mem_delay = 0;
  int last_delay = 0;
  int mem_ops_seen = 0;
  int ack_tok_req = 0;
  int ack_tok_done = 0;

  always @(negedge clk) begin
    if (mem_ack) begin
      mem_ack = 1'b0;
    end else if (ack_tok_req != ack_tok_done) begin
      mem_ack   = 1'b1;
      mem_rdata = 32'hbad0_0bad;
      ack_tok_done++;
    end else if (mem_auto && mem_req && !rst) begin
      if (!mem_busy) begin
        mem_busy = 1'b1;
        mem_ops_seen++;
        check("mem_req_expected", 64'(cur_mem_exp), 64'd1);
        check("mem_we", 64'(mem_we), 64'(cur_mem_we));
        check("mem_addr", 64'(mem_addr), 64'(cur_mem_addr));
        if (cur_mem_we) check("mem_wdata", 64'(mem_wdata), 64'(cur_mem_wdata));
        check("mem_req_timing", 64'(cyc), 64'(acc_cyc + 1));
        mem_delay  = $urandom_range(0, 3);
        last_delay = mem_delay;
      end
      if (mem_delay == 0) begin
        mem_ack   = 1'b1;
        mem_rdata = cur_mem_we ? $urandom : mem_val(mem_addr[31:2]);
        mem_busy  = 1'b0;
      end else begin
        mem_delay--;
      end
    end
  end

  // ---------------- compare process / scoreboard ----------------
  always @(negedge clk) begin
    logic [33:0] e;
    if (rst) begin
      m_hits   = 0;
      m_misses = 0;
      exp_q.delete();
    end else begin
      check("hit_cnt", 64'(hit_cnt), 64'(m_hits));
      check("miss_cnt", 64'(miss_cnt), 64'(m_misses));
      if (cpu_done) begin
        done_total++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: actual=1 expected=0 (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          check("cpu_hit", 64'(cpu_hit), 64'(e[32]));
          if (!e[33]) check("cpu_rdata", 64'(cpu_rdata), 64'(e[31:0]));
          check("mem_ops", 64'(mem_ops_seen - mem_snap), 64'(cur_mem_exp));
          if (e[32]) m_hits++;
          else       m_misses++;
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic do_req(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input bit hold, output int lat);
    int n;
    bit got;
    bit exp_mem;
    n = 0;
    while (!cpu_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cpu_ready) fail("ready_timeout");
    model_access(we, addr, wdata, exp_mem);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    @(posedge clk);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 60) begin
      @(negedge clk);
      lat++;
      if (lat == 1) acc_cyc = cyc;
      if (!hold) cpu_req = 1'b0;
      check("ready_low", 64'(cpu_ready), 64'd0);
      if (cpu_done) got = 1'b1;
    end
    cpu_req = 1'b0;
    if (!got) fail("done_timeout");
    else check("latency", 64'(lat), exp_mem ? 64'(3 + last_delay) : 64'd2);
  endtask

  function automatic logic [31:0] mk_addr(input int tag, input int idx);
    return (32'(tag) << 10) | (32'(idx) << 2);
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    int d0;
    int n;
    bit we;
    logic [31:0] a;

    mem[30'd2570] = 32'd500;
    model_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(cpu_ready), 64'd1);
    check("rst_done", 64'(cpu_done), 64'd0);
    check("rst_rdata", 64'(cpu_rdata), 64'd0);
    check("rst_hit", 64'(cpu_hit), 64'd0);
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    check("rst_hit_cnt", 64'(hit_cnt), 64'd0);
    check("rst_miss_cnt", 64'(miss_cnt), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    rst = 1'b0;
    @(negedge clk);

    // first read of 10280 (index 10, tag 10) misses and fetches 500
    do_req(1'b0, 32'd10280, 32'd0, 1'b0, lat);
    check("t1_hit", 64'(cpu_hit), 64'd0);
    check("t1_rdata", 64'(cpu_rdata), 64'd500);
    @(negedge clk);
    check("t1_miss_cnt", 64'(miss_cnt), 64'd1);

    // repeat read hits; done in the third cycle counting the request cycle
    do_req(1'b0, 32'd10280, 32'd0, 1'b0, lat);
    check("t2_latency", 64'(lat), 64'd2);
    check("t2_hit", 64'(cpu_hit), 64'd1);
    check("t2_rdata", 64'(cpu_rdata), 64'd500);
    @(negedge clk);
    check("t2_hit_cnt", 64'(hit_cnt), 64'd1);

    // write hit goes through to memory, then reads back
    do_req(1'b1, 32'd10280, 32'd15000, 1'b0, lat);
    check("t3_write_hit", 64'(cpu_hit), 64'd1);
    check("t3_mem_wdata", 64'(mem_wdata), 64'd15000);
    do_req(1'b0, 32'd10280, 32'd0, 1'b0, lat);
    check("t3_read_hit", 64'(cpu_hit), 64'd1);
    check("t3_rdata", 64'(cpu_rdata), 64'd15000);

    // fill index 10 with tags 10..13, touch 10, then tag 14 evicts tag 11
    for (int t = 11; t <= 13; t++) do_req(1'b0, mk_addr(t, 10), 32'd0, 1'b0, lat);
    do_req(1'b0, mk_addr(10, 10), 32'd0, 1'b0, lat);
    check("t4_tag10_hit", 64'(cpu_hit), 64'd1);
    do_req(1'b0, mk_addr(14, 10), 32'd0, 1'b0, lat);
    check("t4_tag14_miss", 64'(cpu_hit), 64'd0);
    do_req(1'b0, mk_addr(11, 10), 32'd0, 1'b0, lat);
    check("t4_tag11_evicted", 64'(cpu_hit), 64'd0);
    do_req(1'b0, mk_addr(10, 10), 32'd0, 1'b0, lat);
    check("t4_tag10_kept", 64'(cpu_hit), 64'd1);

    // request held high across a miss produces exactly one completion
    #1 d0 = done_total;
    do_req(1'b0, mk_addr(30, 10), 32'd0, 1'b1, lat);
    repeat (4) @(negedge clk);
    #1 check("held_req_dones", 64'(done_total - d0), 64'd1);

    // randomized traffic over a few hot sets to force evictions
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0) a = $urandom;
      else a = mk_addr($urandom_range(0, 5), $urandom_range(8, 11)) | 32'($urandom_range(0, 3));
      we = ($urandom_range(0, 2) == 0);
      do_req(we, a, $urandom, ($urandom_range(0, 3) == 0), lat);
    end

    // reset while waiting on a memory read
    @(negedge clk);
    mem_auto = 1'b0;
    n = 0;
    while (!cpu_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = mk_addr(20, 10);
    @(posedge clk);
    @(negedge clk);
    cpu_req = 1'b0;
    n = 0;
    while (!mem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t6_mem_req_seen", 64'(mem_req), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("t6_mem_req_drop", 64'(mem_req), 64'd0);
    check("t6_state_idle", 64'(dbg_state), 64'(ST_IDLE));
    @(negedge clk);
    rst = 1'b0;
    ack_tok_req++;
    repeat (4) @(negedge clk);
    check("t6_late_ack_ready", 64'(cpu_ready), 64'd1);
    check("t6_late_ack_no_req", 64'(mem_req), 64'd0);
    model_reset();
    mem_auto = 1'b1;
    do_req(1'b0, 32'd10280, 32'd0, 1'b0, lat);
    check("t6_invalidated_miss", 64'(cpu_hit), 64'd0);
    check("t6_rdata", 64'(cpu_rdata), 64'd15000);
    @(negedge clk);
    check("t6_miss_cnt", 64'(miss_cnt), 64'd1);
    check("t6_hit_cnt", 64'(hit_cnt), 64'd0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
